// File: rtl/mem_req_ctrl_if.sv
// Request/response and memory bus bundle for mem_req_ctrl.
// Handshake: a request is accepted on a rising edge where req_valid && req_ready;
// req_ready is high only while the controller is idle and out of reset, and the
// req_* fields are sampled only on that accepting edge. resp_valid is a single-cycle
// pulse with no backpressure; resp_rdata/resp_err are meaningful only with it.
// The master side is the environment (pipeline MEM stage plus the memory array),
// the slave side is the controller itself.
interface mem_req_ctrl_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wr;
  logic                  req_size;
  logic                  req_sign;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [15:0]           req_wdata;
  logic                  resp_valid;
  logic [15:0]           resp_rdata;
  logic                  resp_err;
  logic                  mem_enable;
  logic                  mem_wr;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [15:0]           mem_wdata;
  logic [15:0]           mem_rdata;

  modport master (
    output req_valid, req_wr, req_size, req_sign, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_enable, mem_wr, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_wr, req_size, req_sign, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_enable, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_req_ctrl.sv
// Initiator-side memory request controller. Converts byte/word, aligned/misaligned
// loads and stores into aligned 16-bit word accesses on a big-endian memory:
// byte stores use read-modify-write, misaligned words are split over two words.
module mem_req_ctrl #(
  parameter int ADDR_WIDTH       = 16,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  mem_req_ctrl_if.slave bus,
  output logic [2:0] dbg_state
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD0  = 3'd1;
  localparam logic [2:0] S_WR0  = 3'd2;
  localparam logic [2:0] S_RD1  = 3'd3;
  localparam logic [2:0] S_WR1  = 3'd4;
  localparam logic [2:0] S_RESP = 3'd5;

  logic [2:0]            state;
  logic [2:0]            state_nx;
  logic                  wr_q;
  logic                  size_q;
  logic                  sign_q;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [15:0]           wdata_q;
  logic [15:0]           old_q;
  logic [15:0]           rdata_q;

  logic                  accept;
  logic                  mis_in;
  logic [ADDR_WIDTH-1:0] addr_e;
  logic [ADDR_WIDTH-1:0] addr_e2;
  logic [7:0]            byte_sel;
  logic [15:0]           byte_ext;
  logic [15:0]           wr0_data;

  assign accept   = bus.req_valid & bus.req_ready;
  assign mis_in   = bus.req_size & bus.req_addr[0];
  // Second word of a split access wraps at the top of the address space.
  assign addr_e   = {addr_q[ADDR_WIDTH-1:1], 1'b0};
  assign addr_e2  = addr_e + ADDR_WIDTH'(2);
  // Big-endian: even byte is the high half of the word.
  assign byte_sel = addr_q[0] ? bus.mem_rdata[7:0] : bus.mem_rdata[15:8];
  assign byte_ext = {{8{sign_q & byte_sel[7]}}, byte_sel};

  assign dbg_state      = state;
  assign bus.req_ready  = (state == S_IDLE) & ~rst;
  assign bus.resp_valid = (state == S_RESP);
  assign bus.resp_rdata = (state == S_RESP) ? rdata_q : 16'h0000;
  assign bus.resp_err   = (state == S_RESP) & err_q;

  // Merge store data into the word read at E (byte RMW or first half of a split word).
  always_comb begin
    wr0_data = wdata_q;
    if (!size_q) begin
      wr0_data = addr_q[0] ? {old_q[15:8], wdata_q[7:0]} : {wdata_q[7:0], old_q[7:0]};
    end else if (addr_q[0]) begin
      wr0_data = {old_q[15:8], wdata_q[15:8]};
    end
  end

  // Next-state sequencing for each access kind.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (mis_in && !ALLOW_MISALIGNED)            state_nx = S_RESP;
          else if (bus.req_size && !bus.req_addr[0] && bus.req_wr) state_nx = S_WR0;
          else                                         state_nx = S_RD0;
        end
      end
      S_RD0: begin
        if (!size_q)        state_nx = wr_q ? S_WR0 : S_RESP;
        else if (addr_q[0]) state_nx = wr_q ? S_WR0 : S_RD1;
        else                state_nx = S_RESP;
      end
      S_WR0:   state_nx = (size_q && addr_q[0]) ? S_RD1 : S_RESP;
      S_RD1:   state_nx = wr_q ? S_WR1 : S_RESP;
      S_WR1:   state_nx = S_RESP;
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Memory bus drive; read and write strobes are mutually exclusive by state.
  always_comb begin
    bus.mem_enable = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = 16'h0000;
    case (state)
      S_RD0: begin
        bus.mem_enable = 1'b1;
        bus.mem_addr   = addr_e;
      end
      S_WR0: begin
        bus.mem_enable = 1'b1;
        bus.mem_wr     = 1'b1;
        bus.mem_addr   = addr_e;
        bus.mem_wdata  = wr0_data;
      end
      S_RD1: begin
        bus.mem_enable = 1'b1;
        bus.mem_addr   = addr_e2;
      end
      S_WR1: begin
        bus.mem_enable = 1'b1;
        bus.mem_wr     = 1'b1;
        bus.mem_addr   = addr_e2;
        bus.mem_wdata  = {wdata_q[7:0], old_q[7:0]};
      end
      default: ;
    endcase
  end

  // State, request capture on accept, and read-data capture in RD cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      wr_q    <= 1'b0;
      size_q  <= 1'b0;
      sign_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 16'h0000;
      old_q   <= 16'h0000;
      rdata_q <= 16'h0000;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (accept) begin
            wr_q    <= bus.req_wr;
            size_q  <= bus.req_size;
            sign_q  <= bus.req_sign;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            err_q   <= mis_in & ~ALLOW_MISALIGNED;
            old_q   <= 16'h0000;
            rdata_q <= 16'h0000;
          end
        end
        S_RD0: begin
          old_q <= bus.mem_rdata;
          if (!wr_q) rdata_q <= size_q ? bus.mem_rdata : byte_ext;
        end
        S_RD1: begin
          old_q <= bus.mem_rdata;
          if (!wr_q) rdata_q <= {old_q[7:0], bus.mem_rdata[15:8]};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Testbench for mem_req_ctrl: table of directed transactions against a word memory
// model, plus hand-written sequences for the no-misaligned variant and a mid-RMW reset.
module tb_mem_req_ctrl;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD1  = 3'd3;

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_req_ctrl_if #(.ADDR_WIDTH(16)) bus ();
  mem_req_ctrl_if #(.ADDR_WIDTH(16)) nm_bus ();
  logic [2:0] dbg;
  logic [2:0] nm_dbg;

  mem_req_ctrl #(.ADDR_WIDTH(16), .ALLOW_MISALIGNED(1'b1)) u_dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg)
  );

  mem_req_ctrl #(.ADDR_WIDTH(16), .ALLOW_MISALIGNED(1'b0)) u_dut_nm (
    .clk(clk), .rst(rst), .bus(nm_bus), .dbg_state(nm_dbg)
  );

  // Word memory model, combinational read, writes on the rising edge
  logic [15:0] mem [0:32767];
  logic        pl_we = 1'b0;
  logic [15:0] pl_addr = 16'h0000;
  logic [15:0] pl_data = 16'h0000;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic        nm_en_seen = 1'b0;

  assign bus.mem_rdata    = mem[bus.mem_addr[15:1]];
  assign nm_bus.mem_rdata = 16'h4242;

  always @(posedge clk) begin
    if (bus.mem_enable && bus.mem_wr) mem[bus.mem_addr[15:1]] <= bus.mem_wdata;
    else if (pl_we)                   mem[pl_addr[15:1]] <= pl_data;
    if (bus.mem_enable && !bus.mem_wr) rd_cnt <= rd_cnt + 1;
    if (bus.mem_enable && bus.mem_wr)  wr_cnt <= wr_cnt + 1;
    if (nm_bus.mem_enable)             nm_en_seen <= 1'b1;
  end

  // Scoreboard counters
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic preload(input logic [15:0] addr, input logic [15:0] data);
    @(negedge clk);
    pl_we   = 1'b1;
    pl_addr = addr;
    pl_data = data;
    @(posedge clk);
    #1;
    pl_we = 1'b0;
  endtask

  task automatic issue(input bit nm, input logic wr, input logic size, input logic sign,
                       input logic [15:0] addr, input logic [15:0] wdata);
    @(negedge clk);
    if (nm) begin
      chk("nm.req_ready_before_accept", 32'(nm_bus.req_ready), 32'd1);
      nm_bus.req_wr = wr; nm_bus.req_size = size; nm_bus.req_sign = sign;
      nm_bus.req_addr = addr; nm_bus.req_wdata = wdata; nm_bus.req_valid = 1'b1;
    end else begin
      chk("req_ready_before_accept", 32'(bus.req_ready), 32'd1);
      bus.req_wr = wr; bus.req_size = size; bus.req_sign = sign;
      bus.req_addr = addr; bus.req_wdata = wdata; bus.req_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    bus.req_valid    = 1'b0;
    nm_bus.req_valid = 1'b0;
  endtask

  task automatic wait_resp(input bit nm, output int lat, output logic [15:0] rdata,
                           output logic err);
    bit done;
    done  = 1'b0;
    lat   = -1;
    rdata = 16'h0000;
    err   = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (!done) begin
        @(negedge clk);
        if (nm ? nm_bus.resp_valid : bus.resp_valid) begin
          done  = 1'b1;
          lat   = c;
          rdata = nm ? nm_bus.resp_rdata : bus.resp_rdata;
          err   = nm ? nm_bus.resp_err : bus.resp_err;
        end
      end
    end
  endtask

  typedef struct {
    logic        wr;
    logic        size;
    logic        sign;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] init_e;
    logic [15:0] init_e2;
    logic [15:0] exp_rdata;
    logic [15:0] exp_e;
    logic [15:0] exp_e2;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int          lat;
    logic [15:0] rdata;
    logic        err;
    logic [15:0] e;
    logic [15:0] e2;
    int          rd0;
    int          wr0;
    bit          resp_seen;

    //          wr    size  sign  addr      wdata     init_e    init_e2   exp_rd    exp_e     exp_e2   lat rd wr
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 16'h0000, 16'hBEEF, 16'hBEEF, 16'h0000, 2, 1, 0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 16'h0011, 16'h00AB, 16'h1234, 16'h5555, 16'h0000, 16'h12AB, 16'h5555, 3, 1, 1};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 16'h0020, 16'h0000, 16'h80FF, 16'h0000, 16'hFF80, 16'h80FF, 16'h0000, 2, 1, 0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000, 16'h80FF, 16'h0000, 16'h0080, 16'h80FF, 16'h0000, 2, 1, 0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 16'hFFFF, 16'hCAFE, 16'h1122, 16'h3344, 16'h0000, 16'h11CA, 16'hFE44, 5, 2, 2};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 16'h0040, 16'h1357, 16'hFFFF, 16'h0000, 16'h0000, 16'h1357, 16'h0000, 2, 0, 1};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 16'h0050, 16'h775A, 16'hABCD, 16'h0000, 16'h0000, 16'h5ACD, 16'h0000, 3, 1, 1};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 16'h0061, 16'h0000, 16'h12F0, 16'h0000, 16'hFFF0, 16'h12F0, 16'h0000, 2, 1, 0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 16'h0071, 16'h0000, 16'hA1B2, 16'hC3D4, 16'hB2C3, 16'hA1B2, 16'hC3D4, 3, 2, 0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h9988, 16'h7766, 16'h8877, 16'h9988, 16'h7766, 3, 2, 0};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 16'h0081, 16'hBEEF, 16'h0102, 16'h0304, 16'h0000, 16'h01BE, 16'hEF04, 5, 2, 2};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 16'h0091, 16'h0000, 16'h34A5, 16'h0000, 16'h00A5, 16'h34A5, 16'h0000, 2, 1, 0};

    bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_size = 1'b0; bus.req_sign = 1'b0;
    bus.req_addr = 16'h0000; bus.req_wdata = 16'h0000;
    nm_bus.req_valid = 1'b0; nm_bus.req_wr = 1'b0; nm_bus.req_size = 1'b0; nm_bus.req_sign = 1'b0;
    nm_bus.req_addr = 16'h0000; nm_bus.req_wdata = 16'h0000;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset.req_ready", 32'(bus.req_ready), 32'd0);
    chk("reset.state", 32'(dbg), 32'(S_IDLE));
    chk("reset.mem_enable", 32'(bus.mem_enable), 32'd0);
    chk("reset.resp_valid", 32'(bus.resp_valid), 32'd0);
    rst = 1'b0;
    #1;
    chk("reset.req_ready_after", 32'(bus.req_ready), 32'd1);

    // Table-driven transactions
    for (int i = 0; i < 12; i++) begin
      e  = vecs[i].addr & 16'hFFFE;
      e2 = e + 16'd2;
      preload(e, vecs[i].init_e);
      preload(e2, vecs[i].init_e2);
      rd0 = rd_cnt;
      wr0 = wr_cnt;
      issue(1'b0, vecs[i].wr, vecs[i].size, vecs[i].sign, vecs[i].addr, vecs[i].wdata);
      wait_resp(1'b0, lat, rdata, err);
      chk($sformatf("v%0d.latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("v%0d.rdata", i), 32'(rdata), 32'(vecs[i].exp_rdata));
      chk($sformatf("v%0d.err", i), 32'(err), 32'd0);
      chk($sformatf("v%0d.mem_e", i), 32'(mem[e[15:1]]), 32'(vecs[i].exp_e));
      chk($sformatf("v%0d.mem_e2", i), 32'(mem[e2[15:1]]), 32'(vecs[i].exp_e2));
      chk($sformatf("v%0d.read_cycles", i), 32'(rd_cnt - rd0), 32'(vecs[i].exp_rd));
      chk($sformatf("v%0d.write_cycles", i), 32'(wr_cnt - wr0), 32'(vecs[i].exp_wr));
      @(negedge clk);
      chk($sformatf("v%0d.resp_one_cycle", i), 32'(bus.resp_valid), 32'd0);
      chk($sformatf("v%0d.ready_after_resp", i), 32'(bus.req_ready), 32'd1);
    end

    // Misaligned rejected when not allowed, then an aligned load still works
    issue(1'b1, 1'b0, 1'b1, 1'b0, 16'h0003, 16'h0000);
    wait_resp(1'b1, lat, rdata, err);
    chk("nm.reject_latency", 32'(lat), 32'd1);
    chk("nm.reject_err", 32'(err), 32'd1);
    chk("nm.reject_rdata", 32'(rdata), 32'd0);
    chk("nm.no_mem_access", 32'(nm_en_seen), 32'd0);
    issue(1'b1, 1'b0, 1'b1, 1'b0, 16'h0004, 16'h0000);
    wait_resp(1'b1, lat, rdata, err);
    chk("nm.aligned_latency", 32'(lat), 32'd2);
    chk("nm.aligned_rdata", 32'(rdata), 32'h4242);
    chk("nm.aligned_err", 32'(err), 32'd0);

    // Reset pulse during RD1 of a misaligned store
    preload(16'h00A0, 16'h1111);
    preload(16'h00A2, 16'h2222);
    issue(1'b0, 1'b1, 1'b1, 1'b0, 16'h00A1, 16'h3344);
    repeat (3) @(negedge clk);
    chk("rst.state_before", 32'(dbg), 32'(S_RD1));
    rst = 1'b1;
    #1;
    chk("rst.state", 32'(dbg), 32'(S_IDLE));
    chk("rst.req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst.mem_enable", 32'(bus.mem_enable), 32'd0);
    chk("rst.mem_wr", 32'(bus.mem_wr), 32'd0);
    chk("rst.mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst.mem_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("rst.resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst.resp_rdata", 32'(bus.resp_rdata), 32'd0);
    chk("rst.resp_err", 32'(bus.resp_err), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    resp_seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.resp_valid) resp_seen = 1'b1;
    end
    chk("rst.no_resp", 32'(resp_seen), 32'd0);
    chk("rst.ready_after", 32'(bus.req_ready), 32'd1);
    chk("rst.first_word_written", 32'(mem[15'h0050]), 32'h1133);
    chk("rst.second_word_kept", 32'(mem[15'h0051]), 32'h2222);

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
